scpad_req_arbiter: RTL and testbench

SCPAD_REQ_ARBITER -- requirements
Module: scpad_req_arbiter

---
 rtl/scpad_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/scpad_req_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_scpad_req_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scpad_pkg.sv
// Shared types and default geometry for the scratchpad request arbiter.
// The bundle structs describe one request/response at the default geometry.
package scpad_pkg;

    localparam int SCPAD_NUM_COLS  = 32;
    localparam int SCPAD_ELEM_BITS = 16;
    localparam int SCPAD_SLOT_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } scpad_state_e;

    typedef struct packed {
        logic                                             write;
        logic [SCPAD_NUM_COLS-1:0]                        mask;
        logic [SCPAD_NUM_COLS-1:0][SCPAD_SLOT_BITS-1:0]   slot;
        logic [SCPAD_NUM_COLS-1:0][SCPAD_ELEM_BITS-1:0]   wdata;
    } scpad_req_t;

    typedef struct packed {
        logic                                             err;
        logic [SCPAD_NUM_COLS-1:0][SCPAD_ELEM_BITS-1:0]   rdata;
    } scpad_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first active request at or after ptr, wrapping around.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scpad_req_arbiter.sv
// Shares one scratchpad body between NUM_REQ requesters, one request in flight.
// Sequence per request: grant (IDLE) -> ISSUE -> WAIT for per-column done -> RESP.
module scpad_req_arbiter
    import scpad_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int NUM_COLS  = SCPAD_NUM_COLS,
    parameter  int ELEM_BITS = SCPAD_ELEM_BITS,
    parameter  int SLOT_BITS = SCPAD_SLOT_BITS,
    parameter  int TIMEOUT   = 64,
    localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                         clk,
    input  logic                                         n_rst,
    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid, once raised, is held with stable payload until then.
    input  logic [NUM_REQ-1:0]                           req_valid,
    output logic [NUM_REQ-1:0]                           req_ready,
    input  logic [NUM_REQ-1:0]                           req_write,
    input  logic [NUM_REQ-1:0][NUM_COLS-1:0]             req_mask,
    input  logic [NUM_REQ-1:0][NUM_COLS-1:0][SLOT_BITS-1:0] req_slot,
    input  logic [NUM_REQ-1:0][NUM_COLS-1:0][ELEM_BITS-1:0] req_wdata,
    output logic                                         spad_valid,
    output logic                                         spad_write,
    output logic [NUM_COLS-1:0]                          spad_mask,
    output logic [NUM_COLS-1:0][SLOT_BITS-1:0]           spad_slot,
    output logic [NUM_COLS-1:0][ELEM_BITS-1:0]           spad_wdata,
    input  logic [NUM_COLS-1:0]                          spad_busy,
    input  logic [NUM_COLS-1:0]                          spad_done,
    input  logic [NUM_COLS-1:0][ELEM_BITS-1:0]           spad_rdata,
    output logic [NUM_REQ-1:0]                           resp_valid,
    input  logic [NUM_REQ-1:0]                           resp_ready,
    output logic [NUM_COLS-1:0][ELEM_BITS-1:0]           resp_rdata,
    output logic                                         resp_err,
    output scpad_state_e                                 dbg_state,
    output logic [PW-1:0]                                dbg_rr_ptr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    scpad_state_e                      state_q, state_d;
    logic [PW-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]                     winner_q, winner_d;
    logic                              write_q, write_d;
    logic [NUM_COLS-1:0]               mask_q, mask_d;
    logic [NUM_COLS-1:0]               pending_q, pending_d;
    logic [NUM_COLS-1:0][SLOT_BITS-1:0] slot_q, slot_d;
    logic [NUM_COLS-1:0][ELEM_BITS-1:0] wdata_q, wdata_d;
    logic [NUM_COLS-1:0][ELEM_BITS-1:0] rbuf_q, rbuf_d;
    logic                              err_q, err_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  grant;
    logic [PW-1:0]       win_idx;
    logic                issue_ok;
    logic [NUM_COLS-1:0] done_hit;
    logic [NUM_COLS-1:0] pending_nxt;
    logic                timeout_hit;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_idx = PW'(i);
        end
    end

    assign issue_ok    = ~|(spad_busy & mask_q);
    assign done_hit    = pending_q & spad_done;
    assign pending_nxt = pending_q & ~spad_done;
    // cnt_q counts completed WAIT cycles, so this fires in the TIMEOUT-th one.
    assign timeout_hit = (cnt_q >= CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            winner_q  <= '0;
            write_q   <= 1'b0;
            mask_q    <= '0;
            pending_q <= '0;
            slot_q    <= '0;
            wdata_q   <= '0;
            rbuf_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            winner_q  <= winner_d;
            write_q   <= write_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            slot_q    <= slot_d;
            wdata_q   <= wdata_d;
            rbuf_q    <= rbuf_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        winner_d  = winner_q;
        write_d   = write_q;
        mask_d    = mask_q;
        pending_d = pending_q;
        slot_d    = slot_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    winner_d  = win_idx;
                    rr_ptr_d  = PW'((int'(win_idx) + 1) % NUM_REQ);
                    write_d   = req_write[win_idx];
                    mask_d    = req_mask[win_idx];
                    slot_d    = req_slot[win_idx];
                    wdata_d   = req_wdata[win_idx];
                    pending_d = '0;
                    rbuf_d    = '0;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = (|req_mask[win_idx]) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                if (issue_ok) begin
                    pending_d = mask_q;
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                pending_d = pending_nxt;
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (done_hit[c] && !write_q) rbuf_d[c] = spad_rdata[c];
                end
                cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
                if (pending_nxt == '0) begin
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready[winner_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // req_ready is combinational off req_valid, so it is also gated by reset.
    always_comb begin
        req_ready  = '0;
        spad_valid = (state_q == ST_ISSUE) && issue_ok;
        spad_write = 1'b0;
        spad_mask  = '0;
        spad_slot  = '0;
        spad_wdata = '0;
        resp_valid = '0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        dbg_state  = state_q;
        dbg_rr_ptr = rr_ptr_q;
        if (state_q == ST_IDLE && n_rst) req_ready = grant;
        if (state_q != ST_IDLE) begin
            spad_write = write_q;
            spad_mask  = mask_q;
            spad_slot  = slot_q;
            spad_wdata = wdata_q;
        end
        if (state_q == ST_RESP) begin
            resp_valid[winner_q] = 1'b1;
            resp_rdata           = rbuf_q;
            resp_err             = err_q;
        end
    end

endmodule

// File: tb/tb_scpad_req_arbiter.sv
// Directed bench for scpad_req_arbiter: read path, round-robin, bank stall,
// timeout, empty mask and mid-operation reset, each with hand-computed values.
module tb_scpad_req_arbiter;
    import scpad_pkg::*;

    localparam int NR = 2;
    localparam int NC = 32;
    localparam int EB = 16;
    localparam int SB = 8;
    localparam int TO = 64;
    localparam int PW = 1;

    logic                            clk = 1'b0;
    logic                            n_rst;
    logic [NR-1:0]                   req_valid, req_ready, req_write;
    logic [NR-1:0][NC-1:0]           req_mask;
    logic [NR-1:0][NC-1:0][SB-1:0]   req_slot;
    logic [NR-1:0][NC-1:0][EB-1:0]   req_wdata;
    logic                            spad_valid, spad_write;
    logic [NC-1:0]                   spad_mask, spad_busy, spad_done;
    logic [NC-1:0][SB-1:0]           spad_slot;
    logic [NC-1:0][EB-1:0]           spad_wdata, spad_rdata;
    logic [NR-1:0]                   resp_valid, resp_ready;
    logic [NC-1:0][EB-1:0]           resp_rdata;
    logic                            resp_err;
    scpad_state_e                    dbg_state;
    logic [PW-1:0]                   dbg_rr_ptr;

    int n_checks = 0;
    int n_fail   = 0;
    int sv_cnt   = 0;
    logic [NR-1:0] exp_q[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (spad_valid) sv_cnt <= sv_cnt + 1;

    scpad_req_arbiter #(
        .NUM_REQ(NR), .NUM_COLS(NC), .ELEM_BITS(EB), .SLOT_BITS(SB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_mask(req_mask), .req_slot(req_slot), .req_wdata(req_wdata),
        .spad_valid(spad_valid), .spad_write(spad_write), .spad_mask(spad_mask),
        .spad_slot(spad_slot), .spad_wdata(spad_wdata),
        .spad_busy(spad_busy), .spad_done(spad_done), .spad_rdata(spad_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid  = '0;
        req_write  = '0;
        req_mask   = '0;
        req_slot   = '0;
        req_wdata  = '0;
        spad_busy  = '0;
        spad_done  = '0;
        spad_rdata = '0;
        resp_ready = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic release_resp(input logic [NR-1:0] rv);
        cyc();
        resp_ready = rv;
        mid();
        cyc();
        resp_ready = '0;
    endtask

    // One full transaction with whichever requester wins; bank answers in 1 cycle.
    task automatic serve_txn(input logic [EB-1:0] rd_val, output logic [NR-1:0] gnt,
                             output logic [NR-1:0] rv, output logic [EB-1:0] rd0,
                             output logic [EB-1:0] rd1, output logic err);
        int n;
        logic [NC-1:0] m;
        n = 0;
        mid();
        while (req_ready == '0 && n < 20) begin mid(); n++; end
        check("txn_grant_seen", req_ready != '0, 1'b1);
        gnt = req_ready;
        n = 0;
        mid();
        while (!spad_valid && n < 20) begin mid(); n++; end
        check("txn_issue_seen", spad_valid, 1'b1);
        m = spad_mask;
        cyc();
        spad_done     = m;
        spad_rdata[0] = rd_val;
        spad_rdata[1] = ~rd_val;
        mid();
        cyc();
        spad_done  = '0;
        spad_rdata = '0;
        n = 0;
        mid();
        while (resp_valid == '0 && n < 10) begin mid(); n++; end
        check("txn_resp_seen", resp_valid != '0, 1'b1);
        rv  = resp_valid;
        rd0 = resp_rdata[0];
        rd1 = resp_rdata[1];
        err = resp_err;
        release_resp(rv);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] gnt, rv, eg;
        logic [EB-1:0] rd0, rd1;
        logic          err;
        logic [1:0]    exp_ptr [3];
        int            sv_before, nwait;

        // ---------------- reset state ----------------
        n_rst = 1'b1;
        clear_inputs();
        #2 n_rst = 1'b0;
        mid();
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_rr_ptr", dbg_rr_ptr, 0);
        check("rst_spad_valid", spad_valid, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_spad_mask", spad_mask, 0);
        check("rst_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        // ---------------- single read, banks done after 2 cycles ----------------
        req_valid      = 2'b01;
        req_write[0]   = 1'b0;
        req_mask[0]    = 32'h3;
        req_slot[0][0] = 8'd5;
        req_slot[0][1] = 8'd9;
        mid();
        check("rd_req_ready", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        mid();
        check("rd_issue_pulse", spad_valid, 1);
        check("rd_spad_mask", spad_mask, 32'h3);
        check("rd_spad_write", spad_write, 0);
        check("rd_spad_slot0", spad_slot[0], 8'd5);
        check("rd_spad_slot1", spad_slot[1], 8'd9);
        cyc();
        mid();
        check("rd_wait1_state", dbg_state, ST_WAIT);
        cyc();
        spad_done     = 32'h3;
        spad_rdata[0] = 16'hAAAA;
        spad_rdata[1] = 16'h5555;
        mid();
        cyc();
        spad_done  = '0;
        spad_rdata = '0;
        mid();
        check("rd_resp_valid", resp_valid, 2'b01);
        check("rd_rdata0", resp_rdata[0], 16'hAAAA);
        check("rd_rdata1", resp_rdata[1], 16'h5555);
        check("rd_rdata2", resp_rdata[2], 0);
        check("rd_err", resp_err, 0);
        cyc();
        mid();
        check("rd_resp_hold", resp_valid, 2'b01);
        check("rd_rdata0_hold", resp_rdata[0], 16'hAAAA);
        release_resp(2'b01);
        mid();
        check("rd_back_idle", dbg_state, ST_IDLE);
        check("rd_resp_drop", resp_valid, 0);
        check("rd_rr_ptr", dbg_rr_ptr, 1);

        // ---------------- round robin with both requesting ----------------
        do_reset();
        req_valid       = 2'b11;
        req_write       = 2'b10;
        req_mask[0]     = 32'h1;
        req_mask[1]     = 32'h2;
        req_wdata[1][1] = 16'h1234;
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_ptr = '{2'd1, 2'd0, 2'd1};
        for (int k = 0; k < 3; k++) begin
            serve_txn(16'h3C00 + 16'(k), gnt, rv, rd0, rd1, err);
            eg = exp_q.pop_front();
            if (k == 2) req_valid = '0;
            check("rr_grant", gnt, eg);
            check("rr_resp_to_winner", rv, eg);
            check("rr_rr_ptr", dbg_rr_ptr, exp_ptr[k]);
            check("rr_rdata0", rd0, (eg == 2'b01) ? 16'h3C00 + 16'(k) : 16'h0);
            check("rr_rdata1", rd1, 0);
            check("rr_err", err, 0);
        end

        // ---------------- bank busy stalls issue ----------------
        req_write    = '0;
        req_mask[0]  = 32'h1;
        spad_busy[0] = 1'b1;
        sv_before    = sv_cnt;
        cyc();
        req_valid = 2'b01;
        mid();
        check("busy_req_ready", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) cyc();
            mid();
            check("busy_stall_valid", spad_valid, 0);
            check("busy_stall_state", dbg_state, ST_ISSUE);
        end
        cyc();
        spad_busy = '0;
        mid();
        check("busy_issue_pulse", spad_valid, 1);
        cyc();
        spad_done     = '1;
        spad_rdata[0] = 16'h0F0F;
        spad_rdata[1] = 16'h7777;
        mid();
        check("busy_single_pulse", spad_valid, 0);
        cyc();
        spad_done  = '0;
        spad_rdata = '0;
        mid();
        check("busy_resp_valid", resp_valid, 2'b01);
        check("busy_rdata0", resp_rdata[0], 16'h0F0F);
        check("busy_ignored_done", resp_rdata[1], 0);
        check("busy_pulse_count", sv_cnt - sv_before, 1);
        release_resp(2'b01);

        // ---------------- timeout with one column never done ----------------
        req_mask[0] = 32'h3;
        req_valid   = 2'b01;
        mid();
        check("to_req_ready", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        mid();
        check("to_issue_pulse", spad_valid, 1);
        nwait = 0;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (k == 0) begin
                spad_done     = 32'h2;
                spad_rdata[1] = 16'hBEEF;
            end else begin
                spad_done  = '0;
                spad_rdata = '0;
            end
            mid();
            if (resp_valid != '0) break;
            if (dbg_state == ST_WAIT) nwait++;
        end
        check("to_wait_cycles", nwait, TO);
        check("to_resp_valid", resp_valid, 2'b01);
        check("to_err", resp_err, 1);
        check("to_rdata0", resp_rdata[0], 0);
        check("to_rdata1", resp_rdata[1], 16'hBEEF);
        release_resp(2'b01);

        // ---------------- empty mask skips the bank ----------------
        req_mask[0] = '0;
        sv_before   = sv_cnt;
        req_valid   = 2'b01;
        mid();
        check("zm_req_ready", req_ready, 2'b01);
        check("zm_no_issue_grant", spad_valid, 0);
        cyc();
        req_valid = '0;
        mid();
        check("zm_resp_valid", resp_valid, 2'b01);
        check("zm_state", dbg_state, ST_RESP);
        check("zm_no_issue", spad_valid, 0);
        check("zm_rdata0", resp_rdata[0], 0);
        check("zm_err", resp_err, 0);
        release_resp(2'b01);
        mid();
        check("zm_pulse_count", sv_cnt - sv_before, 0);

        // ---------------- reset during WAIT ----------------
        cyc();
        req_mask[0] = 32'h1;
        req_valid   = 2'b01;
        mid();
        cyc();
        req_valid = '0;
        mid();
        cyc();
        mid();
        check("mr_in_wait", dbg_state, ST_WAIT);
        check("mr_mask_live", spad_mask, 32'h1);
        n_rst = 1'b0;
        #1;
        check("mr_state", dbg_state, ST_IDLE);
        check("mr_spad_mask", spad_mask, 0);
        check("mr_spad_valid", spad_valid, 0);
        check("mr_resp_valid", resp_valid, 0);
        check("mr_req_ready", req_ready, 0);
        check("mr_rr_ptr", dbg_rr_ptr, 0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("mr_no_resp", resp_valid, 0);
            check("mr_idle", dbg_state, ST_IDLE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
